// File: rtl/pwm_multi_pkg.sv
// Shared constants for the pwm_multi peripheral: register byte offsets,
// CTRL bit positions and the value returned for unmapped reads.
package pwm_multi_pkg;

  localparam logic [5:0] REG_CTRL       = 6'h00;
  localparam logic [5:0] REG_PERIOD     = 6'h04;
  localparam logic [5:0] REG_PRESCALE   = 6'h08;
  localparam logic [5:0] REG_POLARITY   = 6'h0C;
  localparam logic [5:0] REG_STATUS     = 6'h10;
  localparam logic [5:0] REG_LEVEL_BASE = 6'h20;

  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_IE_BIT = 1;

  localparam logic [31:0] RD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/pwm_multi_timebase.sv
// Prescaler and period counter shared by all PWM channels; flags the tick
// on which the counter wraps so the channels can reload their shadow levels.
module pwm_multi_timebase #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_period,
  input  logic [PRE_W-1:0] i_prescale,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_tick,
  output logic             o_wrap
);

  logic [PRE_W-1:0] r_pre_cnt;
  logic [WIDTH-1:0] r_cnt;

  // >= rather than == so that shrinking PRESCALE or PERIOD below the running
  // count ends the current step/period at once instead of running to overflow.
  assign o_tick = i_enable & ~i_clear & (r_pre_cnt >= i_prescale);
  assign o_wrap = o_tick & (r_cnt >= i_period);
  assign o_cnt  = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre_cnt <= '0;
      r_cnt     <= '0;
    end else if (!i_enable || i_clear) begin
      r_pre_cnt <= '0;
      r_cnt     <= '0;
    end else begin
      if (o_tick) r_pre_cnt <= '0;
      else        r_pre_cnt <= r_pre_cnt + 1'b1;
      if (o_wrap)      r_cnt <= '0;
      else if (o_tick) r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM peripheral with programmable period/prescaler, per-channel
// polarity, duty levels double-buffered at period wrap, and a wrap interrupt.
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int PRE_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          addr,
  input  logic [1:0]          write_n,
  input  logic                read_complete,
  input  logic [31:0]         data_in,
  output logic [31:0]         data_out,
  output logic [CHANNELS-1:0] pwm,
  output logic                irq
);

  logic [5:0]          w_addr;
  logic                w_wr;
  logic                w_en_rise;
  logic                w_status_clr;
  logic [WIDTH-1:0]    w_cnt;
  logic                w_tick;
  logic                w_wrap;
  logic [WIDTH-1:0]    w_level [CHANNELS];
  logic                w_unused;

  logic                r_enable;
  logic                r_wrap_ie;
  logic                r_wrap_flag;
  logic [WIDTH-1:0]    r_period;
  logic [PRE_W-1:0]    r_prescale;
  logic [CHANNELS-1:0] r_polarity;

  assign w_addr       = {addr[5:2], 2'b00};
  assign w_wr         = (write_n != 2'b11);
  assign w_en_rise    = w_wr && (w_addr == REG_CTRL) && data_in[CTRL_EN_BIT] && !r_enable;
  assign w_status_clr = w_wr && (w_addr == REG_STATUS) && data_in[0];
  assign w_unused     = &{1'b0, read_complete, addr[1:0], w_tick, data_in};

  pwm_multi_timebase #(
    .WIDTH (WIDTH),
    .PRE_W (PRE_W)
  ) u_timebase (
    .clk        (clk),
    .rst        (rst),
    .i_enable   (r_enable),
    .i_clear    (w_en_rise),
    .i_period   (r_period),
    .i_prescale (r_prescale),
    .o_cnt      (w_cnt),
    .o_tick     (w_tick),
    .o_wrap     (w_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enable   <= 1'b0;
      r_wrap_ie  <= 1'b0;
      r_period   <= '1;
      r_prescale <= '0;
      r_polarity <= '0;
    end else if (w_wr) begin
      case (w_addr)
        REG_CTRL: begin
          r_enable  <= data_in[CTRL_EN_BIT];
          r_wrap_ie <= data_in[CTRL_IE_BIT];
        end
        REG_PERIOD:   r_period   <= data_in[WIDTH-1:0];
        REG_PRESCALE: r_prescale <= data_in[PRE_W-1:0];
        REG_POLARITY: r_polarity <= data_in[CHANNELS-1:0];
        default: ;
      endcase
    end
  end

  // A wrap in the same cycle as a write-1-clear must not be lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_wrap_flag <= 1'b0;
    else if (w_wrap)       r_wrap_flag <= 1'b1;
    else if (w_status_clr) r_wrap_flag <= 1'b0;
  end

  assign irq = r_wrap_flag & r_wrap_ie;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam logic [5:0] LEVEL_ADDR = REG_LEVEL_BASE + 6'(4 * i);

    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] r_shadow;
    logic             r_pwm;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_level  <= '0;
        r_shadow <= '0;
        r_pwm    <= 1'b0;
      end else begin
        if (w_wr && (w_addr == LEVEL_ADDR)) r_level <= data_in[WIDTH-1:0];
        if (w_wrap || w_en_rise)            r_shadow <= r_level;
        r_pwm <= r_enable ? ((w_cnt < r_shadow) ^ r_polarity[i]) : r_polarity[i];
      end
    end

    assign w_level[i] = r_level;
    assign pwm[i]     = r_pwm;
  end

  always_comb begin
    data_out = RD_DEFAULT;
    case (w_addr)
      REG_CTRL:     data_out = {30'b0, r_wrap_ie, r_enable};
      REG_PERIOD:   data_out = 32'(r_period);
      REG_PRESCALE: data_out = 32'(r_prescale);
      REG_POLARITY: data_out = 32'(r_polarity);
      REG_STATUS: begin
        data_out               = '0;
        data_out[0]            = r_wrap_flag;
        data_out[16 +: WIDTH]  = w_cnt;
      end
      default: ;
    endcase
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_addr == REG_LEVEL_BASE + 6'(4 * i)) data_out = 32'(w_level[i]);
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: reset defaults, duty, double buffering,
// edge duties/polarity, prescaler/period shrink and wrap interrupt.
module tb_pwm_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  addr = '0;
  logic [1:0]  write_n = 2'b11;
  logic        read_complete = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic [3:0]  pwm;
  logic        irq;

  int n_vec = 0;
  int n_bad = 0;

  pwm_multi #(.CHANNELS(4), .WIDTH(8), .PRE_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .write_n       (write_n),
    .read_complete (read_complete),
    .data_in       (data_in),
    .data_out      (data_out),
    .pwm           (pwm),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  // Called at a negedge; the write lands on the next posedge, returns at the following negedge.
  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    addr    = a;
    data_in = d;
    write_n = 2'b00;
    @(negedge clk);
    write_n = 2'b11;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = data_out;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    @(negedge clk);
    do_reset();
    n_vec++; if (pwm !== 4'b0000) begin n_bad++; $display("FAIL reset_pwm: got %b expected 0000", pwm); end
    n_vec++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b expected 0", irq); end
    rd(6'h04, d);
    n_vec++; if (d !== 32'h0000_00FF) begin n_bad++; $display("FAIL reset_period: got %h expected 000000ff", d); end
    rd(6'h3C, d);
    n_vec++; if (d !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_undef_3c: got %h expected ffffffff", d); end
    rd(6'h00, d);
    n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl: got %h expected 0", d); end
    rd(6'h10, d);
    n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_status: got %h expected 0", d); end
  endtask

  // Expected pwm[0] after edge k (k=0 is the enabling write): levels 3 then 7 after the wrap at k=10.
  function automatic logic exp_duty(input int k);
    int c;
    int lv;
    c  = (k - 1) % 10;
    lv = ((k - 1) < 10) ? 3 : 7;
    return (c < lv);
  endfunction

  task automatic test_duty_buffer();
    logic [31:0] d;
    wr(6'h04, 32'd9);
    wr(6'h20, 32'd3);
    wr(6'h00, 32'h1);
    n_vec++; if (pwm[0] !== 1'b0) begin n_bad++; $display("FAIL enable_lag k=0: got %b expected 0", pwm[0]); end
    for (int k = 1; k <= 21; k++) begin
      if (k == 6) wr(6'h20, 32'd7);
      else step(1);
      n_vec++;
      if (pwm[0] !== exp_duty(k)) begin
        n_bad++; $display("FAIL duty k=%0d: got %b expected %b", k, pwm[0], exp_duty(k));
      end
      if (k == 9) begin
        rd(6'h10, d);
        n_vec++; if (d !== 32'h0009_0000) begin n_bad++; $display("FAIL status_prewrap: got %h expected 00090000", d); end
      end
      if (k == 10) begin
        rd(6'h10, d);
        n_vec++; if (d !== 32'h0000_0001) begin n_bad++; $display("FAIL status_wrap: got %h expected 00000001", d); end
      end
    end
  endtask

  task automatic test_edges_polarity();
    logic [31:0] d;
    wr(6'h24, 32'd0);
    wr(6'h28, 32'd10);
    step(8);
    for (int j = 0; j < 10; j++) begin
      step(1);
      n_vec++; if (pwm[1] !== 1'b0) begin n_bad++; $display("FAIL level0_ch1 j=%0d: got %b expected 0", j, pwm[1]); end
      n_vec++; if (pwm[2] !== 1'b1) begin n_bad++; $display("FAIL level_over_ch2 j=%0d: got %b expected 1", j, pwm[2]); end
    end
    wr(6'h0C, 32'h2);
    for (int j = 0; j < 10; j++) begin
      step(1);
      n_vec++; if (pwm[1] !== 1'b1) begin n_bad++; $display("FAIL pol_ch1 j=%0d: got %b expected 1", j, pwm[1]); end
      n_vec++; if (pwm[2] !== 1'b1) begin n_bad++; $display("FAIL pol_ch2 j=%0d: got %b expected 1", j, pwm[2]); end
    end
    wr(6'h00, 32'h2);
    step(1);
    n_vec++; if (pwm !== 4'b0010) begin n_bad++; $display("FAIL disabled_pwm: got %b expected 0010", pwm); end
    step(2);
    n_vec++; if (pwm !== 4'b0010) begin n_bad++; $display("FAIL disabled_pwm_hold: got %b expected 0010", pwm); end
    rd(6'h10, d);
    n_vec++; if (d !== 32'h0000_0001) begin n_bad++; $display("FAIL disabled_status: got %h expected 00000001", d); end
    n_vec++; if (irq !== 1'b1) begin n_bad++; $display("FAIL disabled_irq: got %b expected 1", irq); end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] d;
    #2 rst = 1'b1;
    #1;
    n_vec++; if (pwm !== 4'b0000) begin n_bad++; $display("FAIL async_rst_pwm: got %b expected 0000", pwm); end
    n_vec++; if (irq !== 1'b0) begin n_bad++; $display("FAIL async_rst_irq: got %b expected 0", irq); end
    @(negedge clk);
    rst = 1'b0;
    rd(6'h04, d);
    n_vec++; if (d !== 32'h0000_00FF) begin n_bad++; $display("FAIL rst_period: got %h expected 000000ff", d); end
    rd(6'h0C, d);
    n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_polarity: got %h expected 0", d); end
    rd(6'h14, d);
    n_vec++; if (d !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL undef_14: got %h expected ffffffff", d); end
  endtask

  task automatic test_prescaler();
    logic [31:0] d;
    wr(6'h04, 32'd9);
    wr(6'h08, 32'd2);
    wr(6'h00, 32'h1);
    for (int k = 1; k <= 54; k++) begin
      if (k == 49) wr(6'h04, 32'd2);
      else step(1);
      rd(6'h10, d);
      if (k == 2) begin
        n_vec++; if (d !== 32'h0000_0000) begin n_bad++; $display("FAIL pre_k2: got %h expected 00000000", d); end
      end
      if (k == 3) begin
        n_vec++; if (d !== 32'h0001_0000) begin n_bad++; $display("FAIL pre_k3: got %h expected 00010000", d); end
      end
      if (k == 29) begin
        n_vec++; if (d !== 32'h0009_0000) begin n_bad++; $display("FAIL pre_k29: got %h expected 00090000", d); end
      end
      if (k == 30) begin
        n_vec++; if (d !== 32'h0000_0001) begin n_bad++; $display("FAIL pre_wrap_k30: got %h expected 00000001", d); end
      end
      if (k == 48) begin
        n_vec++; if (d !== 32'h0006_0001) begin n_bad++; $display("FAIL pre_k48: got %h expected 00060001", d); end
      end
      if (k == 50) begin
        n_vec++; if (d !== 32'h0006_0001) begin n_bad++; $display("FAIL shrink_k50: got %h expected 00060001", d); end
      end
      if (k == 51) begin
        n_vec++; if (d !== 32'h0000_0001) begin n_bad++; $display("FAIL shrink_wrap_k51: got %h expected 00000001", d); end
      end
      if (k == 54) begin
        n_vec++; if (d !== 32'h0001_0001) begin n_bad++; $display("FAIL shrink_k54: got %h expected 00010001", d); end
      end
    end
  endtask

  task automatic test_interrupt();
    logic [31:0] d;
    do_reset();
    wr(6'h04, 32'd3);
    wr(6'h00, 32'h3);
    step(3);
    n_vec++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_prewrap: got %b expected 0", irq); end
    step(1);
    n_vec++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_wrap: got %b expected 1", irq); end
    step(3);
    wr(6'h10, 32'h1);
    n_vec++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_set_wins: got %b expected 1", irq); end
    rd(6'h10, d);
    n_vec++; if (d !== 32'h0000_0001) begin n_bad++; $display("FAIL status_set_wins: got %h expected 00000001", d); end
    wr(6'h10, 32'h1);
    n_vec++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_cleared: got %b expected 0", irq); end
    rd(6'h10, d);
    n_vec++; if (d !== 32'h0001_0000) begin n_bad++; $display("FAIL status_cleared: got %h expected 00010000", d); end
    wr(6'h00, 32'h1);
    step(2);
    n_vec++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_masked: got %b expected 0", irq); end
    rd(6'h10, d);
    n_vec++; if (d !== 32'h0000_0001) begin n_bad++; $display("FAIL status_masked_wrap: got %h expected 00000001", d); end
  endtask

  initial begin
    test_reset();
    test_duty_buffer();
    test_edges_polarity();
    test_reset_midrun();
    test_prescaler();
    test_interrupt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
